food_scheduler: RTL and testbench
=================================

FOOD_SCHEDULER -- requirements
Module: food_scheduler

Interface
REQ-001 Parameter: MAX_TRIES, default 8, random draws per placement before the fallback scan (range 1..15).
REQ-002 Port: clka  input  1  game clock; all state updates on negedge clka; one clock; reset is synchronous and active-high.
REQ-003 Port: restart  input  1  synchronous active-high reset, sampled at negedge clka.
REQ-004 Port: place_req  input  1  logic datapath request for a new food cell; level or pulse.
REQ-005 Port: occupancy_flat  input  64  snake body map; bit 8*r+c set = row r, column c occupied.
REQ-006 Port: rng_req  output  1  request to PRNG datapath.
REQ-007 Port: rng_ack  input  1  PRNG acknowledge; rng_value is valid while high.
REQ-008 Port: rng_value  input  6  random cell index {row[2:0], col[2:0]}.
REQ-009 Port: food_pos  output  6  placed food index {row, col}.
REQ-010 Port: food_valid  output  1  food_pos holds a current placement.
REQ-011 Port: place_done  output  1  one-cycle pulse when a placement attempt ends.
REQ-012 Port: board_full  output  1  sticky; all 64 cells occupied, no food placeable.

Function
REQ-013 States: IDLE, REQ_RNG, WAIT_RNG, CHECK, SCAN, DONE, FULL.
REQ-014 IDLE: place_req high -> clear food_valid, clear try counter, go to REQ_RNG; if occupancy_flat is all ones at acceptance, go to FULL instead.
REQ-015 place_req is ignored in every state except IDLE; no queuing.
REQ-016 REQ_RNG: assert rng_req only after rng_ack is seen low (four-phase), then go to WAIT_RNG.
REQ-017 WAIT_RNG: hold rng_req high. On the cycle rng_ack is high, capture rng_value, drop rng_req next cycle, and go to CHECK.
REQ-018 CHECK: if occupancy_flat[captured] == 0 -> food_pos <= captured, food_valid <= 1, go to DONE. Otherwise increment the 4-bit try counter.
REQ-019 CHECK, on collision: if the counter equals MAX_TRIES, go to SCAN (macro on) or REQ_RNG (macro off); otherwise go to REQ_RNG.
REQ-020 SCAN: start at (captured+1) mod 64, test one cell per cycle, wrap 63->0. The first free cell loads food_pos and sets food_valid, then go to DONE. Completes in at most 63 cycles.
REQ-021 DONE: place_done = 1 for exactly one cycle, then IDLE.
REQ-022 FULL: board_full <= 1, place_done pulse on entry cycle, food_valid stays 0; remain until restart.
REQ-023 occupancy_flat is sampled live each cycle; the datapath holds it stable from place_req until place_done.
REQ-024 Latency from acceptance to place_done with a free first draw and rng_ack returned 1 cycle after rng_req: 5 cycles.

Reset
REQ-025 restart, regardless of state, forces IDLE next edge: rng_req=0, food_valid=0, food_pos=0, place_done=0, board_full=0, try counter=0, capture register=0.
REQ-026 Reset mid-handshake drops rng_req immediately. The next request still waits for rng_ack low (REQ-016).

Configuration
REQ-027 Macro FOOD_SCAN_FALLBACK_EN: defined -> SCAN state and scan counter are compiled in and used after MAX_TRIES collisions.
REQ-028 FOOD_SCAN_FALLBACK_EN undefined -> no SCAN logic; the block retries draws indefinitely and the try counter saturates at MAX_TRIES.

Structure
REQ-029 Shared package snake_pkg holds: the state encoding, the cell-index width (6), board dimension (8), and the flattening rule index = 8*row + col, shared with the controller and logic datapath.
REQ-030 One sub-module, occupancy_mux (64:1 bit select by 6-bit index), is shared by the CHECK and SCAN paths.

Verification
REQ-031 Empty board, place_req, rng_value=6'd19 ack after 1 cycle -> food_pos=19, food_valid=1, place_done exactly one pulse, 5 cycles after acceptance.
REQ-032 Cells 5,9 occupied, draws 5,9,40 -> 2 collisions, then food_pos=40; rng_req drops between draws and re-rises only after rng_ack goes low.
REQ-033 Macro on, MAX_TRIES=2, all cells occupied except 2, draws 63,63 -> SCAN wraps 0,1,2 -> food_pos=2 and place_done.
REQ-034 occupancy_flat=all ones, place_req -> board_full=1, place_done pulse, food_valid=0, rng_req never asserted; stays full until restart.
REQ-035 restart asserted in WAIT_RNG with rng_req=1 -> next edge all outputs 0, state IDLE; a second place_req is ignored while busy.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: controller state encoding, board
// geometry and the row/column flattening rule index = 8*row + col.
package snake_pkg;

    localparam int CELL_W    = 6;
    localparam int BOARD_DIM = 8;
    localparam int NUM_CELLS = BOARD_DIM * BOARD_DIM;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_RNG,
        ST_WAIT_RNG,
        ST_CHECK,
        ST_SCAN,
        ST_DONE,
        ST_FULL
    } state_t;

    // {row, col} with 3-bit fields is exactly 8*row + col.
    function automatic logic [CELL_W-1:0] cell_index(input logic [2:0] row,
                                                     input logic [2:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/occupancy_mux.sv
// 64:1 occupancy bit select, shared by the CHECK and SCAN paths of
// food_scheduler.
module occupancy_mux
    import snake_pkg::*;
(
    input  logic [NUM_CELLS-1:0] i_occ,
    input  logic [CELL_W-1:0]    i_idx,
    output logic                 o_bit
);

    logic [CELL_W-1:0] w_idx;

    // Split the index into row/column and re-flatten through the shared rule.
    always_comb begin
        w_idx = cell_index(i_idx[5:3], i_idx[2:0]);
        o_bit = i_occ[w_idx];
    end

endmodule

// File: rtl/food_scheduler.sv
// Food placement controller: draws random cells from the PRNG over a
// four-phase handshake until a free cell is found. When FOOD_SCAN_FALLBACK_EN
// is defined, a linear scan takes over after MAX_TRIES collisions; otherwise
// draws repeat indefinitely. All state updates on the falling edge of clka.
module food_scheduler
    import snake_pkg::*;
#(
    parameter int unsigned MAX_TRIES = 8
)(
    input  logic                 clka,
    input  logic                 restart,
    input  logic                 place_req,
    input  logic [NUM_CELLS-1:0] occupancy_flat,
    output logic                 rng_req,
    input  logic                 rng_ack,
    input  logic [CELL_W-1:0]    rng_value,
    output logic [CELL_W-1:0]    food_pos,
    output logic                 food_valid,
    output logic                 place_done,
    output logic                 board_full
);

    localparam logic [3:0] TRY_LIMIT = 4'(MAX_TRIES);

    state_t            r_state;
    logic [3:0]        r_tries;
    logic [CELL_W-1:0] r_cap;
    logic              r_rng_req;
    logic [CELL_W-1:0] r_food_pos;
    logic              r_food_valid;
    logic              r_place_done;
    logic              r_board_full;
    logic [CELL_W-1:0] w_idx;
    logic              w_occ;
    logic [3:0]        w_tries_inc;
`ifdef FOOD_SCAN_FALLBACK_EN
    logic [CELL_W-1:0] r_scan;
`endif

    // Cell under test: the scan pointer while scanning, else the captured draw.
    always_comb begin
`ifdef FOOD_SCAN_FALLBACK_EN
        w_idx = (r_state == ST_SCAN) ? r_scan : r_cap;
`else
        w_idx = r_cap;
`endif
        w_tries_inc = r_tries + 4'd1;
    end

    occupancy_mux u_occ_mux (
        .i_occ (occupancy_flat),
        .i_idx (w_idx),
        .o_bit (w_occ)
    );

    // Placement FSM with registered outputs; restart overrides everything.
    always_ff @(negedge clka) begin
        if (restart) begin
            r_state      <= ST_IDLE;
            r_tries      <= 4'd0;
            r_cap        <= '0;
            r_rng_req    <= 1'b0;
            r_food_pos   <= '0;
            r_food_valid <= 1'b0;
            r_place_done <= 1'b0;
            r_board_full <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
            r_scan       <= '0;
`endif
        end else begin
            r_place_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (place_req) begin
                        r_food_valid <= 1'b0;
                        r_tries      <= 4'd0;
                        if (&occupancy_flat) begin
                            r_board_full <= 1'b1;
                            r_place_done <= 1'b1;
                            r_state      <= ST_FULL;
                        end else begin
                            r_state <= ST_REQ_RNG;
                        end
                    end
                end
                ST_REQ_RNG: begin
                    // Four-phase: previous acknowledge must have returned low.
                    if (!rng_ack) begin
                        r_rng_req <= 1'b1;
                        r_state   <= ST_WAIT_RNG;
                    end
                end
                ST_WAIT_RNG: begin
                    if (rng_ack) begin
                        r_cap     <= rng_value;
                        r_rng_req <= 1'b0;
                        r_state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!w_occ) begin
                        r_food_pos   <= r_cap;
                        r_food_valid <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
`ifdef FOOD_SCAN_FALLBACK_EN
                        r_tries <= w_tries_inc;
                        if (w_tries_inc == TRY_LIMIT) begin
                            r_scan  <= r_cap + 6'd1;
                            r_state <= ST_SCAN;
                        end else begin
                            r_state <= ST_REQ_RNG;
                        end
`else
                        if (r_tries != TRY_LIMIT) begin
                            r_tries <= w_tries_inc;
                        end
                        r_state <= ST_REQ_RNG;
`endif
                    end
                end
`ifdef FOOD_SCAN_FALLBACK_EN
                ST_SCAN: begin
                    // Board is known not full, so a free cell exists within 63 steps.
                    if (!w_occ) begin
                        r_food_pos   <= r_scan;
                        r_food_valid <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
                        r_scan <= r_scan + 6'd1;
                    end
                end
`endif
                ST_DONE: begin
                    r_place_done <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                ST_FULL: begin
                    r_state <= ST_FULL;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rng_req    = r_rng_req;
    assign food_pos   = r_food_pos;
    assign food_valid = r_food_valid;
    assign place_done = r_place_done;
    assign board_full = r_board_full;

endmodule

// File: tb/tb_food_scheduler.sv
// Self-checking bench for food_scheduler: PRNG responder with configurable or
// random handshake delays, a transaction-level model of the placement rules,
// directed placements with literal expectations and randomized placements.
module tb_food_scheduler;

`ifdef FOOD_SCAN_FALLBACK_EN
    localparam int MT = 2;
`else
    localparam int MT = 8;
`endif

    logic        clka = 1'b0;
    logic        restart;
    logic        place_req;
    logic [63:0] occupancy_flat;
    logic        rng_req;
    logic        rng_ack;
    logic [5:0]  rng_value;
    logic [5:0]  food_pos;
    logic        food_valid;
    logic        place_done;
    logic        board_full;

    int          n_vec = 0;
    int          n_err = 0;
    int          ack_dly = 1;
    int          drop_dly = 0;
    bit          rand_mode = 1'b0;
    logic [5:0]  draw_q[$];
    logic [5:0]  txn[$];

    food_scheduler #(.MAX_TRIES(MT)) dut (
        .clka           (clka),
        .restart        (restart),
        .place_req      (place_req),
        .occupancy_flat (occupancy_flat),
        .rng_req        (rng_req),
        .rng_ack        (rng_ack),
        .rng_value      (rng_value),
        .food_pos       (food_pos),
        .food_valid     (food_valid),
        .place_done     (place_done),
        .board_full     (board_full)
    );

    always #5 clka = ~clka;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // PRNG responder: four-phase slave, acts on rising edges (away from the DUT edge).
    initial begin : prng
        int cnt;
        cnt = 0;
        rng_ack = 1'b0;
        rng_value = 6'd0;
        forever begin
            @(posedge clka);
            if (!rng_ack) begin
                if (rng_req === 1'b1) begin
                    if (cnt >= ack_dly) begin
                        if (draw_q.size() > 0) rng_value = draw_q.pop_front();
                        else rng_value = 6'($urandom_range(0, 63));
                        rng_ack = 1'b1;
                        cnt = 0;
                        if (rand_mode) drop_dly = $urandom_range(0, 2);
                    end else cnt++;
                end else cnt = 0;
            end else begin
                if (rng_req === 1'b0) begin
                    if (cnt >= drop_dly) begin
                        rng_ack = 1'b0;
                        cnt = 0;
                        if (rand_mode) ack_dly = $urandom_range(0, 3);
                    end else cnt++;
                end else cnt = 0;
            end
        end
    end

    // Transaction-level model and per-cycle compare, sampled just after each falling edge.
    initial begin : cmp
        bit          busy, full_m, mval, prev_req, was_busy, exp_ok;
        logic [5:0]  mpos, expp, c;
        logic [63:0] tocc;
        int          lat, expn;
        busy = 0; full_m = 0; mval = 0; prev_req = 0; mpos = 0; tocc = 0; lat = 0;
        forever begin
            @(negedge clka);
            #1;
            if (restart) begin
                chk("restart_outs", 64'({rng_req, food_valid, food_pos, place_done, board_full}), 64'd0);
                busy = 0; full_m = 0; mval = 0; mpos = 0;
                txn.delete();
            end else begin
                was_busy = busy;
                if (prev_req && rng_ack) txn.push_back(rng_value);
                if (!prev_req && rng_req === 1'b1)
                    chk("req_rise_ack_low", 64'(rng_ack), 64'd0);
                if (was_busy) begin
                    lat++;
                    chk("busy_board_full", 64'(board_full), 64'd0);
                    if (place_done === 1'b1) begin
                        exp_ok = 0; expn = 0; expp = 0;
                        for (int i = 0; i < txn.size(); i++) begin
                            if (!tocc[txn[i]]) begin
                                expp = txn[i]; expn = i + 1; exp_ok = 1;
                                break;
                            end
`ifdef FOOD_SCAN_FALLBACK_EN
                            if (i + 1 == MT) begin
                                for (int k = 1; k < 64; k++) begin
                                    c = 6'(int'(txn[i]) + k);
                                    if (!tocc[c]) begin expp = c; break; end
                                end
                                expn = i + 1; exp_ok = 1;
                                break;
                            end
`endif
                        end
                        chk("done_has_result", 64'(exp_ok), 64'd1);
                        chk("draw_count", 64'(txn.size()), 64'(expn));
                        chk("done_food_pos", 64'(food_pos), 64'(expp));
                        chk("done_food_valid", 64'(food_valid), 64'd1);
                        busy = 0; mval = 1; mpos = expp;
                    end else if (lat > 8000) begin
                        chk("placement_timeout", 64'(place_done), 64'd1);
                        busy = 0;
                    end
                end else if (full_m) begin
                    chk("full_outs", 64'({board_full, food_valid, rng_req, place_done}), 64'b1000);
                end else if (place_req) begin
                    if (&occupancy_flat) begin
                        full_m = 1; mval = 0;
                        chk("full_entry", 64'({board_full, food_valid, rng_req, place_done}), 64'b1001);
                    end else begin
                        busy = 1; lat = 0; tocc = occupancy_flat; mval = 0;
                        txn.delete();
                        chk("accept_outs", 64'({food_valid, place_done, board_full}), 64'd0);
                    end
                end else begin
                    chk("idle_outs", 64'({food_valid, food_pos, rng_req, place_done, board_full}),
                        64'({mval, mpos, 3'b000}));
                end
            end
            prev_req = (rng_req === 1'b1);
        end
    end

    task automatic place(input logic [63:0] occ, input bit extra, output int lat, output bit done);
        @(posedge clka);
        occupancy_flat = occ;
        place_req = 1'b1;
        @(negedge clka);
        #1;
        lat = 0;
        done = (place_done === 1'b1);
        @(posedge clka);
        place_req = extra;
        while (!done && lat < 9000) begin
            @(negedge clka);
            #1;
            lat++;
            if (place_done === 1'b1) done = 1;
            if (lat == 1) begin
                @(posedge clka);
                place_req = 1'b0;
            end
        end
        place_req = 1'b0;
        draw_q.delete();
    endtask

    initial begin : main
        int         lat, w;
        bit         done;
        logic [63:0] occ;
        restart = 1'b1;
        place_req = 1'b0;
        occupancy_flat = 64'd0;
        repeat (3) @(posedge clka);
        @(negedge clka);
        #1;
        chk("reset_outs", 64'({rng_req, food_valid, food_pos, place_done, board_full}), 64'd0);
        @(posedge clka);
        restart = 1'b0;

        // Empty board, free first draw, ack one cycle after request.
        ack_dly = 1; drop_dly = 0;
        draw_q = '{6'd19};
        place(64'd0, 1'b0, lat, done);
        chk("t31_done", 64'(done), 64'd1);
        chk("t31_latency", 64'(lat), 64'd5);
        chk("t31_pos", 64'(food_pos), 64'd19);
        chk("t31_valid", 64'(food_valid), 64'd1);

        // Two collisions then a free draw; ack drops one cycle late.
        ack_dly = 1; drop_dly = 1;
        draw_q = '{6'd5, 6'd9, 6'd40};
        place((64'd1 << 5) | (64'd1 << 9), 1'b0, lat, done);
        chk("t32_done", 64'(done), 64'd1);
        chk("t32_pos", 64'(food_pos), 64'd40);
        chk("t32_draws", 64'(txn.size()), 64'd3);

        // Long run of collisions; only cell 7 is free.
        ack_dly = 0; drop_dly = 0;
        draw_q = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd8, 6'd9, 6'd10, 6'd11, 6'd7};
        place(~(64'd1 << 7), 1'b0, lat, done);
        chk("retry_done", 64'(done), 64'd1);
        chk("retry_pos", 64'(food_pos), 64'd7);
`ifdef FOOD_SCAN_FALLBACK_EN
        chk("retry_draws", 64'(txn.size()), 64'd2);
`else
        chk("retry_draws", 64'(txn.size()), 64'd12);
`endif

`ifdef FOOD_SCAN_FALLBACK_EN
        // Scan wraps past 63 to reach the single free cell 2.
        ack_dly = 1; drop_dly = 0;
        draw_q = '{6'd63, 6'd63};
        place(~(64'd1 << 2), 1'b0, lat, done);
        chk("t33_done", 64'(done), 64'd1);
        chk("t33_pos", 64'(food_pos), 64'd2);
`endif

        // Randomized placements with random delays and values.
        rand_mode = 1'b1;
        for (int t = 0; t < 30; t++) begin
            int m;
            m = $urandom_range(0, 2);
            occ = {$urandom, $urandom};
            if (m == 0) occ = occ & {$urandom, $urandom};
            else if (m == 1) occ = occ | {$urandom, $urandom};
            else begin
                occ = '1;
                occ[$urandom_range(0, 63)] = 1'b0;
            end
            if (&occ) occ[0] = 1'b0;
            place(occ, ($urandom_range(0, 3) == 0), lat, done);
            chk("rnd_done", 64'(done), 64'd1);
        end
        rand_mode = 1'b0;
        ack_dly = 1; drop_dly = 0;
        repeat (4) @(posedge clka);

        // Full board: immediate done, sticky board_full until restart.
        place('1, 1'b0, lat, done);
        chk("t34_done", 64'(done), 64'd1);
        chk("t34_latency", 64'(lat), 64'd0);
        chk("t34_full", 64'(board_full), 64'd1);
        chk("t34_valid", 64'(food_valid), 64'd0);
        @(posedge clka); place_req = 1'b1;
        @(posedge clka); place_req = 1'b0;
        repeat (4) @(posedge clka);
        chk("t34_still_full", 64'(board_full), 64'd1);
        restart = 1'b1;
        @(posedge clka); restart = 1'b0;
        @(negedge clka); #1;
        chk("t34_cleared", 64'(board_full), 64'd0);

        // Restart while waiting on the PRNG; a second request while busy is ignored.
        ack_dly = 8; drop_dly = 0;
        @(posedge clka); occupancy_flat = 64'd0; place_req = 1'b1;
        @(posedge clka); place_req = 1'b0;
        w = 0;
        while (rng_req !== 1'b1 && w < 20) begin @(posedge clka); w++; end
        chk("t35_req_up", 64'(rng_req), 64'd1);
        place_req = 1'b1;
        @(posedge clka); place_req = 1'b0; restart = 1'b1;
        @(negedge clka); #1;
        chk("t35_rst_outs", 64'({rng_req, food_valid, food_pos, place_done, board_full}), 64'd0);
        @(posedge clka); restart = 1'b0;

        ack_dly = 1;
        draw_q = '{6'd33};
        place(64'd0, 1'b0, lat, done);
        chk("t35_after_pos", 64'(food_pos), 64'd33);
        chk("t35_after_latency", 64'(lat), 64'd5);

        repeat (3) @(posedge clka);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
